ram_port_arbiter: RTL

- Shares the collector's single-port byte-wide buffer RAM between NREQ requesters, typically the receiver write paths and the transmitter read paths.
- Grants at most one RAM access per cycle, round-robin, with optional write priority for overflow-sensitive receivers.
- Includes a starvation guard for readers and a 2-cycle read-return pipeline.
- Sits between the per-port channel logic and the RAM pins (o_addr/o_D/WE/RE/i_D).

---
 rtl/ram_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide single-port buffer RAM between
// NREQ requesters. Optional write priority is backed by a starvation guard
// for readers. Read data returns through a 2-stage one-hot tag pipeline.
module ram_port_arbiter #(
  parameter int NREQ   = 11,
  parameter int AW     = 14,
  parameter int WPRI   = 1,
  parameter int STARVE = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_we,
  input  logic [NREQ*AW-1:0]   i_addr,
  input  logic [NREQ*8-1:0]    i_wdata,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_rvalid,
  output logic [7:0]           o_rdata,
  output logic [AW-1:0]        o_addr,
  output logic [7:0]           o_D,
  output logic                 WE,
  output logic                 RE,
  input  logic [7:0]           i_D
);

  // The pointer and the starvation counter are 4 bits wide, which covers
  // NREQ <= 16 and STARVE <= 15.
  localparam int PW = 4;
  localparam int SW = 4;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic [NREQ-1:0] tag1_q, tag1_d;
  logic [NREQ-1:0] tag2_q, tag2_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [NREQ-1:0] rd_pend, wr_pend, cand, gnt_vec;
  logic            found, grant, win_we, rd_any;
  int              win_idx, scan_idx;

  // Candidate selection and round-robin scan starting just after rr_ptr.
  always_comb begin
    rd_pend  = i_req & ~i_we;
    wr_pend  = i_req & i_we;
    cand     = i_req;
    found    = 1'b0;
    win_idx  = 0;
    scan_idx = 0;
    gnt_vec  = '0;
    if (WPRI != 0) begin
      if (starve_q == SW'(STARVE) && (|rd_pend)) cand = rd_pend;
      else if (|wr_pend)                          cand = wr_pend;
    end
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!found && cand[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
    // Grant is suppressed while reset is asserted.
    if (found && i_rst) gnt_vec[win_idx] = 1'b1;
    win_we = i_we[win_idx];
  end

  // Next-state for command register, pointer, starvation guard and read pipe.
  always_comb begin
    grant    = |gnt_vec;
    rd_any   = |rd_pend;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    tag1_d   = '0;
    tag2_d   = tag1_q;
    rdata_d  = re_q ? i_D : rdata_q;
    starve_d = starve_q;
    if (grant) begin
      addr_d   = i_addr[win_idx*AW +: AW];
      wdata_d  = i_wdata[win_idx*8 +: 8];
      we_d     = win_we;
      re_d     = !win_we;
      rr_ptr_d = PW'(win_idx);
      if (!win_we) tag1_d = gnt_vec;
    end
    if (rd_any && grant && win_we) begin
      if (starve_q != SW'(STARVE)) starve_d = starve_q + 1'b1;
    end else if (!rd_any || (grant && !win_we)) begin
      starve_d = '0;
    end
  end

  // State registers; reset discards any in-flight read tags.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr_q <= PW'(NREQ - 1);
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      tag1_q   <= '0;
      tag2_q   <= '0;
      rdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag2_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_gnt    = gnt_vec;
  assign o_rvalid = tag2_q;
  assign o_rdata  = rdata_q;
  assign o_addr   = addr_q;
  assign o_D      = wdata_q;
  assign WE       = we_q;
  assign RE       = re_q;

endmodule
